pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It tracks the destination register of each in-flight instruction in an internal EX/MEM/WB scoreboard. From that it drives the PC and pipeline-register enables, bubble/flush controls and operand-forwarding selects, and it counts stall and flush events. It holds no datapath values.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX request signals in, pipeline control,
// forwarding selects and event counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W    = 16,
    parameter int XLEN_IDX = 5
);
    logic                id_valid;
    logic [XLEN_IDX-1:0] id_rs1;
    logic [XLEN_IDX-1:0] id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [XLEN_IDX-1:0] id_rd;
    logic                id_wr;
    logic                id_load;
    logic                ex_busy;
    logic                ex_br_taken;

    logic                pc_en;
    logic                if_id_en;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                id_byp_a;
    logic                id_byp_b;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr, id_load, ex_busy, ex_br_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble,
               fwd_a, fwd_b, id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr, id_load, ex_busy, ex_br_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble,
               fwd_a, fwd_b, id_byp_a, id_byp_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RV32I pipeline: EX/MEM/WB
// destination scoreboard, stall/flush/bubble control, forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int XLEN_IDX = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz_if
);

    typedef struct packed {
        logic                valid;
        logic [XLEN_IDX-1:0] rd;
        logic                wr;
        logic                load;
        logic [XLEN_IDX-1:0] rs1;
        logic [XLEN_IDX-1:0] rs2;
        logic                use_rs1;
        logic                use_rs2;
    } slot_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_BUSY,
        MODE_FLUSH,
        MODE_STALL
    } mode_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_LOAD  = 2'b11
    } fwd_e;

    localparam slot_t SLOT_NONE = '0;

    // A producer slot feeds source src only if it really writes a non-x0 rd
    // and the consumer actually reads that source.
    function automatic logic f_match(slot_t p, logic [XLEN_IDX-1:0] src, logic use_src);
        return p.valid && p.wr && (p.rd != '0) && (p.rd == src) && use_src;
    endfunction

    function automatic fwd_e f_fwd_sel(slot_t mem, slot_t wb,
                                       logic [XLEN_IDX-1:0] src, logic use_src);
        if (f_match(mem, src, use_src)) begin
            return mem.load ? FWD_LOAD : FWD_EXMEM;
        end
        if (f_match(wb, src, use_src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    slot_t            w_id_entry;
    logic             w_load_use;
    mode_e            w_mode;

    always_comb begin
        w_id_entry.valid   = hz_if.id_valid;
        w_id_entry.rd      = hz_if.id_rd;
        w_id_entry.wr      = hz_if.id_wr;
        w_id_entry.load    = hz_if.id_load;
        w_id_entry.rs1     = hz_if.id_rs1;
        w_id_entry.rs2     = hz_if.id_rs2;
        w_id_entry.use_rs1 = hz_if.id_use_rs1;
        w_id_entry.use_rs2 = hz_if.id_use_rs2;
    end

    assign w_load_use = hz_if.id_valid && r_ex.load &&
                        (f_match(r_ex, hz_if.id_rs1, hz_if.id_use_rs1) ||
                         f_match(r_ex, hz_if.id_rs2, hz_if.id_use_rs2));

    // Priority: multi-cycle EX freezes everything, then branch flush, then
    // load-use. Reset forces the quiet mode so outputs settle immediately.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path can leave it unassigned and infer a latch.
        w_mode = MODE_RUN;
        if (rst) begin
            if (hz_if.ex_busy) begin
                w_mode = MODE_BUSY;
            end else if (hz_if.ex_br_taken) begin
                w_mode = MODE_FLUSH;
            end else if (w_load_use) begin
                w_mode = MODE_STALL;
            end
        end
    end

    always_comb begin
        hz_if.pc_en        = 1'b1;
        hz_if.if_id_en     = 1'b1;
        hz_if.if_id_flush  = 1'b0;
        hz_if.id_ex_bubble = 1'b0;
        unique case (w_mode)
            MODE_BUSY: begin
                hz_if.pc_en    = 1'b0;
                hz_if.if_id_en = 1'b0;
            end
            MODE_FLUSH: begin
                hz_if.if_id_flush  = 1'b1;
                hz_if.id_ex_bubble = 1'b1;
            end
            MODE_STALL: begin
                hz_if.pc_en        = 1'b0;
                hz_if.if_id_en     = 1'b0;
                hz_if.id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign hz_if.fwd_a    = f_fwd_sel(r_mem, r_wb, r_ex.rs1, r_ex.use_rs1);
    assign hz_if.fwd_b    = f_fwd_sel(r_mem, r_wb, r_ex.rs2, r_ex.use_rs2);
    assign hz_if.id_byp_a = f_match(r_wb, hz_if.id_rs1, hz_if.id_use_rs1);
    assign hz_if.id_byp_b = f_match(r_wb, hz_if.id_rs2, hz_if.id_use_rs2);

    // While EX is busy its slot holds and MEM receives a bubble.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // slot samples the pre-edge value of the one before it.
        if (!rst) begin
            r_ex  <= SLOT_NONE;
            r_mem <= SLOT_NONE;
            r_wb  <= SLOT_NONE;
        end else begin
            r_wb <= r_mem;
            if (w_mode == MODE_BUSY) begin
                r_mem <= SLOT_NONE;
            end else begin
                r_mem <= r_ex;
                r_ex  <= (hz_if.id_ex_bubble || !hz_if.id_valid) ? SLOT_NONE : w_id_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_mode == MODE_STALL && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_mode == MODE_FLUSH && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz_if.stall_cnt = r_stall_cnt;
    assign hz_if.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle expected outputs are
// queued with the stimulus and compared when the DUT outputs settle.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W    = 16;
    localparam int XLEN_IDX = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W), .XLEN_IDX(XLEN_IDX)) hz ();
    pipeline_hazard_ctrl_if #(.CNT_W(2), .XLEN_IDX(XLEN_IDX)) hz_sat ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .XLEN_IDX(XLEN_IDX)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (hz)
    );

    // Narrow-counter copy driven in lockstep with the main instance.
    pipeline_hazard_ctrl #(.CNT_W(2), .XLEN_IDX(XLEN_IDX)) dut_sat (
        .clk   (clk),
        .rst   (rst),
        .hz_if (hz_sat)
    );

    assign hz_sat.id_valid    = hz.id_valid;
    assign hz_sat.id_rs1      = hz.id_rs1;
    assign hz_sat.id_rs2      = hz.id_rs2;
    assign hz_sat.id_use_rs1  = hz.id_use_rs1;
    assign hz_sat.id_use_rs2  = hz.id_use_rs2;
    assign hz_sat.id_rd       = hz.id_rd;
    assign hz_sat.id_wr       = hz.id_wr;
    assign hz_sat.id_load     = hz.id_load;
    assign hz_sat.ex_busy     = hz.ex_busy;
    assign hz_sat.ex_br_taken = hz.ex_br_taken;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
    } instr_t;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_bubble;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic        byp_a;
        logic        byp_b;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
        logic [1:0]  sat_stall;
        logic [1:0]  sat_flush;
    } obs_t;

    typedef enum {K_RUN, K_STALL, K_FLUSH, K_BUSY} kind_e;

    typedef struct {
        instr_t ins;
        logic   busy;
        logic   br;
        obs_t   e;
    } step_t;

    localparam instr_t NOP = '0;

    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    obs_t sb[$];

    function automatic instr_t mk(logic ld, int rd, int rs1, logic u1, int rs2, logic u2);
        instr_t r;
        r.valid = 1'b1;
        r.rd    = 5'(rd);
        r.wr    = 1'b1;
        r.load  = ld;
        r.rs1   = 5'(rs1);
        r.use1  = u1;
        r.rs2   = 5'(rs2);
        r.use2  = u2;
        return r;
    endfunction

    function automatic instr_t op_r(int rd, int rs1, int rs2);
        return mk(1'b0, rd, rs1, 1'b1, rs2, 1'b1);
    endfunction

    function automatic instr_t op_i(int rd, int rs1);
        return mk(1'b0, rd, rs1, 1'b1, 0, 1'b0);
    endfunction

    function automatic instr_t op_lw(int rd, int rs1);
        return mk(1'b1, rd, rs1, 1'b1, 0, 1'b0);
    endfunction

    function automatic logic [1:0] sat2(int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // Builds one cycle's stimulus and its expected outputs; the counters
    // seen this cycle are the ones accumulated before it.
    function automatic step_t mk_step(instr_t ins, logic busy, logic br, kind_e k,
                                      logic [1:0] fa, logic [1:0] fb, logic ba, logic bb);
        step_t s;
        s.ins  = ins;
        s.busy = busy;
        s.br   = br;
        case (k)
            K_STALL: {s.e.pc_en, s.e.if_id_en, s.e.if_id_flush, s.e.id_ex_bubble} = 4'b0001;
            K_FLUSH: {s.e.pc_en, s.e.if_id_en, s.e.if_id_flush, s.e.id_ex_bubble} = 4'b1111;
            K_BUSY:  {s.e.pc_en, s.e.if_id_en, s.e.if_id_flush, s.e.id_ex_bubble} = 4'b0000;
            default: {s.e.pc_en, s.e.if_id_en, s.e.if_id_flush, s.e.id_ex_bubble} = 4'b1100;
        endcase
        s.e.fwd_a     = fa;
        s.e.fwd_b     = fb;
        s.e.byp_a     = ba;
        s.e.byp_b     = bb;
        s.e.stall_cnt = 16'(m_stall);
        s.e.flush_cnt = 16'(m_flush);
        s.e.sat_stall = sat2(m_stall);
        s.e.sat_flush = sat2(m_flush);
        if (k == K_STALL) m_stall++;
        if (k == K_FLUSH) m_flush++;
        return s;
    endfunction

    function automatic step_t run(instr_t ins, logic [1:0] fa, logic [1:0] fb, logic ba, logic bb);
        return mk_step(ins, 1'b0, 1'b0, K_RUN, fa, fb, ba, bb);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pc_en=%b if_id_en=%b flush=%b bubble=%b fwd_a=%b fwd_b=%b byp_a=%b byp_b=%b stall_cnt=%0d flush_cnt=%0d sat_stall=%0d sat_flush=%0d",
                         o.pc_en, o.if_id_en, o.if_id_flush, o.id_ex_bubble, o.fwd_a, o.fwd_b,
                         o.byp_a, o.byp_b, o.stall_cnt, o.flush_cnt, o.sat_stall, o.sat_flush);
    endfunction

    task automatic drive(input step_t s);
        hz.id_valid    = s.ins.valid;
        hz.id_rd       = s.ins.rd;
        hz.id_wr       = s.ins.wr;
        hz.id_load     = s.ins.load;
        hz.id_rs1      = s.ins.rs1;
        hz.id_use_rs1  = s.ins.use1;
        hz.id_rs2      = s.ins.rs2;
        hz.id_use_rs2  = s.ins.use2;
        hz.ex_busy     = s.busy;
        hz.ex_br_taken = s.br;
        sb.push_back(s.e);
    endtask

    task automatic sample(output obs_t o);
        o.pc_en        = hz.pc_en;
        o.if_id_en     = hz.if_id_en;
        o.if_id_flush  = hz.if_id_flush;
        o.id_ex_bubble = hz.id_ex_bubble;
        o.fwd_a        = hz.fwd_a;
        o.fwd_b        = hz.fwd_b;
        o.byp_a        = hz.id_byp_a;
        o.byp_b        = hz.id_byp_b;
        o.stall_cnt    = hz.stall_cnt;
        o.flush_cnt    = hz.flush_cnt;
        o.sat_stall    = hz_sat.stall_cnt;
        o.sat_flush    = hz_sat.flush_cnt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            hz.id_valid = 1'b0; hz.id_rd = '0; hz.id_wr = 1'b0; hz.id_load = 1'b0;
            hz.id_rs1 = '0; hz.id_use_rs1 = 1'b0; hz.id_rs2 = '0; hz.id_use_rs2 = 1'b0;
            hz.ex_busy = 1'b0; hz.ex_br_taken = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        obs_t got, want;
        drive(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_held: got %s, expected %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_release: got %s, expected %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        obs_t  got, want;
        st.push_back(run(op_i(3, 1),      2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(4, 3, 3),   2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(7, 3, 1),   2'b01, 2'b01, 1'b0, 1'b0));
        st.push_back(run(NOP,             2'b10, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(9, 3, 4),   2'b00, 2'b00, 1'b0, 1'b1));
        st.push_back(run(op_i(11, 1),     2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_i(11, 11),    2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(12, 11, 11), 2'b01, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,             2'b01, 2'b01, 1'b0, 1'b0));
        st.push_back(run(NOP,             2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t st[$];
        obs_t  got, want;
        st.push_back(run(op_lw(5, 1), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(mk_step(op_r(6, 5, 2), 1'b0, 1'b0, K_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(6, 5, 2), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,           2'b10, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_lw(7, 1),   2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(mk_step(op_r(8, 2, 7), 1'b0, 1'b0, K_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(8, 2, 7), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,           2'b00, 2'b10, 1'b0, 1'b0));
        st.push_back(run(op_lw(9, 1),   2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(mk(1'b0, 10, 9, 1'b0, 0, 1'b0), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,           2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_flush();
        step_t st[$];
        obs_t  got, want;
        st.push_back(run(op_lw(5, 1), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(mk_step(op_r(6, 5, 2), 1'b0, 1'b1, K_FLUSH, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(mk_step(NOP, 1'b1, 1'b1, K_BUSY, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(mk_step(op_i(7, 1), 1'b0, 1'b1, K_FLUSH, 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_flush[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        step_t st[$];
        obs_t  got, want;
        st.push_back(run(op_i(0, 1),    2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_lw(0, 1),   2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(2, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(3, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_r(4, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,           2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL x0[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ex_busy();
        step_t st[$];
        obs_t  got, want;
        st.push_back(run(op_i(3, 1), 2'b00, 2'b00, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk_step(op_r(4, 3, 1), 1'b1, 1'b0, K_BUSY, 2'b00, 2'b00, 1'b0, 1'b0));
        end
        st.push_back(run(op_r(4, 3, 1), 2'b00, 2'b00, 1'b0, 1'b0));
        st.push_back(run(NOP,           2'b01, 2'b00, 1'b0, 1'b0));
        st.push_back(run(op_i(9, 3),    2'b00, 2'b00, 1'b1, 1'b0));
        st.push_back(run(NOP,           2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ex_busy[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        step_t st[$];
        obs_t  got, want;
        for (int k = 0; k < 3; k++) begin
            st.push_back(run(op_lw(5, 1), 2'b00, 2'b00, 1'b0, 1'b0));
            st.push_back(mk_step(op_r(6, 5, 2), 1'b0, 1'b0, K_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
            st.push_back(run(op_r(6, 5, 2), 2'b00, 2'b00, 1'b0, 1'b0));
            st.push_back(run(NOP,           2'b10, 2'b00, 1'b0, 1'b0));
        end
        for (int k = 0; k < 2; k++) begin
            st.push_back(mk_step(NOP, 1'b0, 1'b1, K_FLUSH, 2'b00, 2'b00, 1'b0, 1'b0));
        end
        st.push_back(run(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            sample(got);
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturation[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t got, want;
        drive(run(op_lw(5, 1), 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_stall_setup: got %s, expected %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
        drive(mk_step(op_r(6, 5, 2), 1'b0, 1'b0, K_STALL, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_stall_active: got %s, expected %s", fmt(got), fmt(want));
        end
        #2;
        rst = 1'b0;
        m_stall = 0;
        m_flush = 0;
        sb.push_back(run(op_r(6, 5, 2), 2'b00, 2'b00, 1'b0, 1'b0).e);
        #1;
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_async: got %s, expected %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(run(op_r(6, 5, 2), 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        sample(got);
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_after_release: got %s, expected %s", fmt(got), fmt(want));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle(1);
        test_reset();
        idle(3);
        test_back_to_back();
        idle(3);
        test_load_use();
        idle(3);
        test_branch_flush();
        idle(3);
        test_x0();
        idle(3);
        test_ex_busy();
        idle(3);
        test_saturation();
        idle(3);
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
